btb_predictor: RTL and testbench

Parametrised branch-target predictor for the 16-bit pipelined core. It is a direct-mapped BTB with tagged entries and per-entry 2-bit saturating counters, with an optional gshare mode that XORs a global history register into the index. It sits beside the IF/ID stage: the lookup is combinational on the fetch PC, and updates arrive from the branch-resolving stage. Performance counters for predictions and mispredicts are included.

---
 rtl/bp_pkg.sv | 21 ++
 rtl/sat_counter2.sv | 20 ++
 rtl/btb_predictor.sv | 122 ++++++++++++
 tb/tb_btb_predictor.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: counter encodings and width helpers.
package bp_pkg;

    // 2-bit direction counter states
    localparam logic [1:0] CntSnt = 2'b00;
    localparam logic [1:0] CntWnt = 2'b01;
    localparam logic [1:0] CntWt  = 2'b10;
    localparam logic [1:0] CntSt  = 2'b11;

    localparam logic [1:0] CntInitDefault = CntWnt;

    function automatic int unsigned idx_bits(input int unsigned entries);
        return $clog2(entries);
    endfunction

    function automatic int unsigned tag_bits(input int unsigned word_size,
                                             input int unsigned entries);
        return word_size - $clog2(entries);
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating up/down counter next-state logic.
module sat_counter2
    import bp_pkg::*;
(
    input  logic [1:0] cnt_i,
    input  logic       inc_i,
    output logic [1:0] cnt_o
);

    // Step towards the taken or not-taken end, clamping at 11 and 00
    always_comb begin
        cnt_o = cnt_i;
        if (inc_i) begin
            if (cnt_i != CntSt) cnt_o = cnt_i + 2'd1;
        end else begin
            if (cnt_i != CntSnt) cnt_o = cnt_i - 2'd1;
        end
    end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped tagged BTB with 2-bit counters, optional gshare indexing and perf counters.
module btb_predictor
    import bp_pkg::*;
#(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned ENTRIES   = 64,
    parameter int unsigned HIST_BITS = 0,
    parameter logic [1:0]  CNT_INIT  = CntInitDefault,
    localparam int unsigned GHW      = (HIST_BITS > 0) ? HIST_BITS : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,   // active-high asynchronous reset
    input  logic [WORD_SIZE-1:0] lookup_pc,
    output logic                 pred_hit,
    output logic                 pred_taken,
    output logic [WORD_SIZE-1:0] pred_next_pc,
    output logic [GHW-1:0]       pred_ghr,
    input  logic                 upd_valid,
    input  logic [WORD_SIZE-1:0] upd_pc,
    input  logic [GHW-1:0]       upd_ghr,
    input  logic                 upd_taken,
    input  logic [WORD_SIZE-1:0] upd_target,
    input  logic                 upd_mispredict,
    input  logic                 stall,
    output logic [15:0]          num_pred,
    output logic [15:0]          num_mispredict
);

    localparam int unsigned IDX = idx_bits(ENTRIES);
    localparam int unsigned TAG = tag_bits(WORD_SIZE, ENTRIES);

    logic [ENTRIES-1:0]   valid_q;
    logic [TAG-1:0]       tag_q [ENTRIES];
    logic [WORD_SIZE-1:0] tgt_q [ENTRIES];
    logic [1:0]           cnt_q [ENTRIES];

    logic [GHW-1:0] ghr_q, ghr_d;
    logic [15:0]    num_pred_q, num_pred_d;
    logic [15:0]    num_mis_q, num_mis_d;

    logic [IDX-1:0] lk_hash, up_hash, lk_idx, up_idx;
    logic           up_hit;
    logic [1:0]     cnt_upd;

    // History hashing; bimodal keeps the GHR pinned at zero
    if (HIST_BITS == 0) begin : g_bimodal
        logic unused_upd_ghr;
        assign unused_upd_ghr = ^upd_ghr;
        assign lk_hash = '0;
        assign up_hash = '0;
        assign ghr_d   = '0;
    end else begin : g_gshare
        assign lk_hash = IDX'(ghr_q);
        assign up_hash = IDX'(upd_ghr);
        if (HIST_BITS == 1) begin : g_h1
            assign ghr_d = upd_taken;
        end else begin : g_hn
            assign ghr_d = {upd_ghr[HIST_BITS-2:0], upd_taken};
        end
    end

    assign lk_idx   = lookup_pc[IDX-1:0] ^ lk_hash;
    assign up_idx   = upd_pc[IDX-1:0] ^ up_hash;
    assign up_hit   = valid_q[up_idx] && (tag_q[up_idx] == upd_pc[WORD_SIZE-1:IDX]);
    assign pred_ghr = ghr_q;

    sat_counter2 u_cnt (
        .cnt_i (cnt_q[up_idx]),
        .inc_i (upd_taken),
        .cnt_o (cnt_upd)
    );

    // Combinational lookup on the fetch PC; valid masks unreset array contents
    always_comb begin
        pred_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lookup_pc[WORD_SIZE-1:IDX]);
        pred_taken   = pred_hit && cnt_q[lk_idx][1];
        pred_next_pc = pred_taken ? tgt_q[lk_idx] : lookup_pc + WORD_SIZE'(1);
    end

    // Saturating perf counter next state
    always_comb begin
        num_pred_d = num_pred_q;
        num_mis_d  = num_mis_q;
        if (!stall && pred_hit && (num_pred_q != 16'hFFFF)) num_pred_d = num_pred_q + 16'd1;
        if (upd_valid && upd_mispredict && (num_mis_q != 16'hFFFF)) num_mis_d = num_mis_q + 16'd1;
    end

    // Resettable state: valid bits, history and perf counters
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            valid_q    <= '0;
            ghr_q      <= '0;
            num_pred_q <= '0;
            num_mis_q  <= '0;
        end else begin
            num_pred_q <= num_pred_d;
            num_mis_q  <= num_mis_d;
            if (upd_valid) begin
                ghr_q <= ghr_d;
                if (!up_hit && upd_taken) valid_q[up_idx] <= 1'b1;
            end
        end
    end

    // Entry payload; allocation only happens on taken, so CNT_INIT never lands here today
    always_ff @(posedge clk) begin
        if (upd_valid && !reset_n) begin
            if (up_hit) begin
                cnt_q[up_idx] <= cnt_upd;
                if (upd_taken) tgt_q[up_idx] <= upd_target;
            end else if (upd_taken) begin
                tag_q[up_idx] <= upd_pc[WORD_SIZE-1:IDX];
                tgt_q[up_idx] <= upd_target;
                cnt_q[up_idx] <= upd_taken ? CntWt : CNT_INIT;
            end
        end
    end

    assign num_pred       = num_pred_q;
    assign num_mispredict = num_mis_q;

endmodule

// File: tb/tb_btb_predictor.sv
// Bench for btb_predictor: a bimodal and a gshare instance share stimulus and are checked
// against a table-based reference model, plus directed constant checks.
module tb_btb_predictor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] lookup_pc = '0;
    logic        upd_valid = 1'b0;
    logic [15:0] upd_pc = '0;
    logic [1:0]  upd_ghr = '0;
    logic        upd_taken = 1'b0;
    logic [15:0] upd_target = '0;
    logic        upd_mispredict = 1'b0;
    logic        stall = 1'b0;

    logic        hit_b, taken_b, hit_g, taken_g;
    logic [15:0] npc_b, npc_g, np_b, np_g, nm_b, nm_g;
    logic [0:0]  ghr_b;
    logic [1:0]  ghr_g;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    btb_predictor #(.HIST_BITS(0)) dut_b (
        .clk(clk), .reset_n(rst), .lookup_pc(lookup_pc),
        .pred_hit(hit_b), .pred_taken(taken_b), .pred_next_pc(npc_b), .pred_ghr(ghr_b),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr[0]), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict), .stall(stall),
        .num_pred(np_b), .num_mispredict(nm_b)
    );

    btb_predictor #(.HIST_BITS(2)) dut_g (
        .clk(clk), .reset_n(rst), .lookup_pc(lookup_pc),
        .pred_hit(hit_g), .pred_taken(taken_g), .pred_next_pc(npc_g), .pred_ghr(ghr_g),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict), .stall(stall),
        .num_pred(np_g), .num_mispredict(nm_g)
    );

    // Reference model: index 0 = bimodal, 1 = gshare (2 history bits)
    bit mv   [2][64];
    int mtag [2][64];
    int mtgt [2][64];
    int mcnt [2][64];
    int mghr [2];
    int mnp  [2];
    int mnm  [2];

    logic        obs_hit_b, obs_taken_b, obs_hit_g;
    logic [15:0] obs_npc_b, obs_npc_g, obs_nm_b, obs_np_b;
    logic [1:0]  obs_ghr_g;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int m_idx(input int m, input int pc, input int g);
        return (pc & 63) ^ ((m == 1) ? (g & 3) : 0);
    endfunction

    function automatic bit m_hit(input int m, input int pc);
        int i;
        i = m_idx(m, pc, mghr[m]);
        return mv[m][i] && (mtag[m][i] == (pc >> 6));
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 64; i++) mv[m][i] = 1'b0;
            mghr[m] = 0;
            mnp[m]  = 0;
            mnm[m]  = 0;
        end
    endtask

    // Drive one cycle (called at a negedge), check outputs, advance the model past the posedge
    task automatic do_cycle(input logic [15:0] pc, input bit uv, input logic [15:0] upc,
                            input logic [1:0] ug, input bit ut, input logic [15:0] utgt,
                            input bit um, input bit st);
        bit eh [2];
        lookup_pc = pc; upd_valid = uv; upd_pc = upc; upd_ghr = ug; upd_taken = ut;
        upd_target = utgt; upd_mispredict = um; stall = st;
        #1;
        obs_hit_b = hit_b; obs_taken_b = taken_b; obs_npc_b = npc_b; obs_np_b = np_b;
        obs_nm_b = nm_b; obs_hit_g = hit_g; obs_npc_g = npc_g; obs_ghr_g = ghr_g;
        for (int m = 0; m < 2; m++) begin
            int i, en;
            bit et;
            i = m_idx(m, int'(pc), mghr[m]);
            eh[m] = m_hit(m, int'(pc));
            et = eh[m] && (mcnt[m][i] >= 2);
            en = et ? mtgt[m][i] : ((int'(pc) + 1) & 16'hFFFF);
            check_eq(m ? "hit_g" : "hit_b", m ? hit_g : hit_b, eh[m]);
            check_eq(m ? "taken_g" : "taken_b", m ? taken_g : taken_b, et);
            check_eq(m ? "npc_g" : "npc_b", m ? npc_g : npc_b, en);
            check_eq(m ? "ghr_g" : "ghr_b", m ? ghr_g : ghr_b, mghr[m]);
            check_eq(m ? "num_pred_g" : "num_pred_b", m ? np_g : np_b, mnp[m]);
            check_eq(m ? "num_misp_g" : "num_misp_b", m ? nm_g : nm_b, mnm[m]);
        end
        for (int m = 0; m < 2; m++) begin
            if (!st && eh[m] && mnp[m] < 16'hFFFF) mnp[m]++;
            if (uv && um && mnm[m] < 16'hFFFF) mnm[m]++;
            if (uv) begin
                int i, t;
                i = m_idx(m, int'(upc), int'(ug));
                t = int'(upc) >> 6;
                if (mv[m][i] && mtag[m][i] == t) begin
                    mcnt[m][i] = ut ? ((mcnt[m][i] < 3) ? mcnt[m][i] + 1 : 3)
                                    : ((mcnt[m][i] > 0) ? mcnt[m][i] - 1 : 0);
                    if (ut) mtgt[m][i] = int'(utgt);
                end else if (ut) begin
                    mv[m][i] = 1'b1; mtag[m][i] = t; mtgt[m][i] = int'(utgt); mcnt[m][i] = 2;
                end
                if (m == 1) mghr[1] = ((int'(ug) & 1) << 1) | int'(ut);
            end
        end
        @(negedge clk);
    endtask

    task automatic look(input logic [15:0] pc);
        do_cycle(pc, 1'b0, 16'h0, 2'b00, 1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic upd(input logic [15:0] pc, input logic [15:0] upc, input logic [1:0] ug,
                       input bit ut, input logic [15:0] utgt);
        do_cycle(pc, 1'b1, upc, ug, ut, utgt, 1'b0, 1'b0);
    endtask

    task automatic apply_reset();
        #2 rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [15:0] pool [4] = '{16'h0010, 16'h0050, 16'h0020, 16'h0030};

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        look(16'h0010);
        check_eq("rst_hit", obs_hit_b, 1'b0);
        check_eq("rst_npc", obs_npc_b, 16'h0011);
        check_eq("rst_num_pred", obs_np_b, 16'h0);
        check_eq("rst_num_misp", obs_nm_b, 16'h0);

        // Bimodal allocate, then two not-taken steps
        upd(16'h0010, 16'h0010, 2'b00, 1'b1, 16'h0040);
        check_eq("same_cycle_alloc_hit", obs_hit_b, 1'b0);
        look(16'h0010);
        check_eq("alloc_hit", obs_hit_b, 1'b1);
        check_eq("alloc_taken", obs_taken_b, 1'b1);
        check_eq("alloc_npc", obs_npc_b, 16'h0040);
        upd(16'h0010, 16'h0010, 2'b00, 1'b0, 16'h0);
        upd(16'h0010, 16'h0010, 2'b00, 1'b0, 16'h0);
        look(16'h0010);
        check_eq("snt_hit", obs_hit_b, 1'b1);
        check_eq("snt_taken", obs_taken_b, 1'b0);
        check_eq("snt_npc", obs_npc_b, 16'h0011);

        // Alias: 0x0050 evicts 0x0010 from the same index
        upd(16'h0000, 16'h0010, 2'b00, 1'b1, 16'h0040);
        upd(16'h0000, 16'h0050, 2'b00, 1'b1, 16'h0077);
        look(16'h0010);
        check_eq("alias_old_hit", obs_hit_b, 1'b0);
        look(16'h0050);
        check_eq("alias_new_npc", obs_npc_b, 16'h0077);

        // Saturation and no-bypass
        repeat (5) upd(16'h0000, 16'h0010, 2'b00, 1'b1, 16'h0040);
        upd(16'h0010, 16'h0010, 2'b00, 1'b0, 16'h0);
        check_eq("sat_concurrent_taken", obs_taken_b, 1'b1);
        check_eq("sat_concurrent_npc", obs_npc_b, 16'h0040);
        look(16'h0010);
        check_eq("sat_wt_taken", obs_taken_b, 1'b1);
        upd(16'h0000, 16'h0010, 2'b00, 1'b0, 16'h0);
        look(16'h0010);
        check_eq("sat_wnt_taken", obs_taken_b, 1'b0);

        // Gshare indexing
        apply_reset();
        upd(16'h0000, 16'h0010, 2'b01, 1'b1, 16'h0040);
        look(16'h0010);
        check_eq("gs_ghr_after", obs_ghr_g, 2'b11);
        check_eq("gs_ghr11_hit", obs_hit_g, 1'b0);
        upd(16'h0000, 16'h0030, 2'b00, 1'b1, 16'h0099);
        look(16'h0010);
        check_eq("gs_ghr01_ghr", obs_ghr_g, 2'b01);
        check_eq("gs_ghr01_hit", obs_hit_g, 1'b1);
        check_eq("gs_ghr01_npc", obs_npc_g, 16'h0040);
        upd(16'h0000, 16'h0030, 2'b00, 1'b0, 16'h0);
        look(16'h0010);
        check_eq("gs_ghr00_hit", obs_hit_g, 1'b0);

        // Mispredict count and asynchronous reset between edges
        repeat (3) do_cycle(16'h0010, 1'b1, 16'h0020, 2'b00, 1'b1, 16'h0021, 1'b1, 1'b0);
        look(16'h0010);
        check_eq("misp3", obs_nm_b, 16'd3);
        lookup_pc = 16'h0010;
        upd_valid = 1'b1; upd_pc = 16'h0010; upd_taken = 1'b1; upd_mispredict = 1'b1;
        #3 rst = 1'b1;
        #1;
        check_eq("arst_misp_b", nm_b, 16'd0);
        check_eq("arst_misp_g", nm_g, 16'd0);
        check_eq("arst_hit_b", hit_b, 1'b0);
        check_eq("arst_npc_b", npc_b, 16'h0011);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        look(16'h0010);
        look(16'h0020);

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            logic [15:0] lpc, upcv;
            lpc  = ($urandom_range(0, 4) == 4) ? 16'($urandom) : pool[$urandom_range(0, 3)];
            upcv = ($urandom_range(0, 4) == 4) ? 16'($urandom) : pool[$urandom_range(0, 3)];
            do_cycle(lpc, 1'($urandom_range(0, 1)), upcv, 2'($urandom), 1'($urandom_range(0, 1)),
                     16'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end

        // Prediction counter saturation
        apply_reset();
        upd(16'h0000, 16'h0010, 2'b00, 1'b1, 16'h0040);
        lookup_pc = 16'h0010; upd_valid = 1'b0; stall = 1'b0; upd_mispredict = 1'b0;
        for (int m = 0; m < 2; m++)
            if (m_hit(m, 16'h0010)) mnp[m] = (mnp[m] + 70000 > 16'hFFFF) ? 16'hFFFF : mnp[m] + 70000;
        repeat (70000) @(negedge clk);
        look(16'h0010);
        check_eq("num_pred_sat", obs_np_b, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
